// File: rtl/adder_sweep_ctrl.sv
// Operand sweeper and result checker for a WIDTH-bit adder: walks every (x, y)
// pair up to the captured limits, compares the adder output with x + y and counts mismatches.
module adder_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_lim,
    input  logic [WIDTH-1:0] y_lim,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             busy,
    output logic             done,
    output logic [ERRW-1:0]  err_cnt,
    output logic             err_flag,
    output logic [WIDTH-1:0] first_err_x,
    output logic [WIDTH-1:0] first_err_y
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] x_lim_r;
    logic [WIDTH-1:0] y_lim_r;
    logic [WIDTH:0]   expected_s;
    logic [WIDTH:0]   actual_s;
    logic             mismatch_s;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        if (v == {ERRW{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ERRW'(1);
        end
    endfunction

    // Compare is one bit wider than the operands so the carry is checked too.
    always_comb begin
        expected_s = {1'b0, x_o} + {1'b0, y_o};
        actual_s   = {cout_i, sum_i};
        mismatch_s = (expected_s != actual_s);
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_o         <= {WIDTH{1'b0}};
            y_o         <= {WIDTH{1'b0}};
            x_lim_r     <= {WIDTH{1'b0}};
            y_lim_r     <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cnt     <= {ERRW{1'b0}};
            err_flag    <= 1'b0;
            first_err_x <= {WIDTH{1'b0}};
            first_err_y <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= DRIVE;
                        x_o         <= {WIDTH{1'b0}};
                        y_o         <= {WIDTH{1'b0}};
                        x_lim_r     <= x_lim;
                        y_lim_r     <= y_lim;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err_cnt     <= {ERRW{1'b0}};
                        err_flag    <= 1'b0;
                        first_err_x <= {WIDTH{1'b0}};
                        first_err_y <= {WIDTH{1'b0}};
                    end
                end
                DRIVE: begin
                    state_r <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch_s) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!err_flag) begin
                            err_flag    <= 1'b1;
                            first_err_x <= x_o;
                            first_err_y <= y_o;
                        end
                    end
                    // y is the inner loop; the last pair leaves the operands untouched.
                    if (y_o < y_lim_r) begin
                        y_o     <= y_o + WIDTH'(1);
                        state_r <= DRIVE;
                    end else if (x_o < x_lim_r) begin
                        y_o     <= {WIDTH{1'b0}};
                        x_o     <= x_o + WIDTH'(1);
                        state_r <= DRIVE;
                    end else begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Self-checking bench: two sweepers (ERRW 8 and 2) each drive a behavioural adder
// with selectable faults; results are predicted by plain nested loops over the pairs.
module tb_adder_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] x_lim = 3'd0;
    logic [2:0] y_lim = 3'd0;

    logic [2:0] x_a, y_a, sum_a, fx_a, fy_a;
    logic       cout_a, busy_a, done_a, flag_a;
    logic [7:0] cnt_a;
    logic [2:0] x_b, y_b, sum_b, fx_b, fy_b;
    logic       cout_b, busy_b, done_b, flag_b;
    logic [1:0] cnt_b;

    int mode = 0;
    int seed = 0;
    int checks = 0;
    int passes = 0;

    adder_sweep_ctrl #(.WIDTH(3), .ERRW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x_lim(x_lim), .y_lim(y_lim),
        .x_o(x_a), .y_o(y_a), .sum_i(sum_a), .cout_i(cout_a),
        .busy(busy_a), .done(done_a), .err_cnt(cnt_a), .err_flag(flag_a),
        .first_err_x(fx_a), .first_err_y(fy_a)
    );

    adder_sweep_ctrl #(.WIDTH(3), .ERRW(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .x_lim(x_lim), .y_lim(y_lim),
        .x_o(x_b), .y_o(y_b), .sum_i(sum_b), .cout_i(cout_b),
        .busy(busy_b), .done(done_b), .err_cnt(cnt_b), .err_flag(flag_b),
        .first_err_x(fx_b), .first_err_y(fy_b)
    );

    always #5 clk = ~clk;

    // Adder under test: 0 correct, 1 Sum[0] stuck at 0, 2 all ones, 3 pseudo-random corruption.
    function automatic logic [3:0] adder_model(input int x, input int y, input int m, input int s);
        int r;
        r = x + y;
        case (m)
            1: r = r & 14;
            2: r = 15;
            3: if (((x * 5 + y * 3 + s) % 4) == 0) r = r ^ 5;
            default: r = x + y;
        endcase
        return r[3:0];
    endfunction

    always_comb {cout_a, sum_a} = adder_model(int'(x_a), int'(y_a), mode, seed);
    always_comb {cout_b, sum_b} = adder_model(int'(x_b), int'(y_b), mode, seed);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Runs one sweep and checks pair order, timing, and final error results of both DUTs.
    task automatic run_sweep(input int xl, input int yl, input int m, input int s, input bit poke);
        int px[$];
        int py[$];
        int cnt8, cnt2, fx, fy, flag;
        mode = m;
        seed = s;
        cnt8 = 0; cnt2 = 0; fx = 0; fy = 0; flag = 0;
        for (int x = 0; x <= xl; x++) begin
            for (int y = 0; y <= yl; y++) begin
                px.push_back(x);
                py.push_back(y);
                if (int'(adder_model(x, y, m, s)) != x + y) begin
                    if (cnt8 < 255) cnt8++;
                    if (cnt2 < 3) cnt2++;
                    if (flag == 0) begin
                        flag = 1; fx = x; fy = y;
                    end
                end
            end
        end
        @(negedge clk);
        x_lim = 3'(xl);
        y_lim = 3'(yl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_lim = 3'(xl ^ 5);
        y_lim = 3'(yl ^ 3);
        check("first_pair_clear", {22'd0, cnt_a, flag_a, cnt_b},
              32'd0);
        for (int n = 0; n < px.size(); n++) begin
            check("pair_a", {24'd0, busy_a, done_a, x_a, y_a},
                  {24'd0, 2'b10, 3'(px[n]), 3'(py[n])});
            check("pair_b", {24'd0, busy_b, done_b, x_b, y_b},
                  {24'd0, 2'b10, 3'(px[n]), 3'(py[n])});
            if (poke && n == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        check("end_state_a", {30'd0, busy_a, done_a}, 32'd1);
        check("end_state_b", {30'd0, busy_b, done_b}, 32'd1);
        check("err_cnt_a", {24'd0, cnt_a}, 32'(cnt8));
        check("err_cnt_b", {30'd0, cnt_b}, 32'(cnt2));
        check("first_err_a", {25'd0, flag_a, fx_a, fy_a}, {25'd0, 1'(flag), 3'(fx), 3'(fy)});
        check("first_err_b", {25'd0, flag_b, fx_b, fy_b}, {25'd0, 1'(flag), 3'(fx), 3'(fy)});
        check("last_ops", {26'd0, x_a, y_a}, {26'd0, 3'(xl), 3'(yl)});
        @(negedge clk);
        check("done_hold", {23'd0, done_a, busy_a, cnt_a}, {23'd0, 1'b1, 1'b0, 8'(cnt8)});
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_a", {13'd0, x_a, y_a, busy_a, done_a, cnt_a, flag_a, fx_a, fy_a}, 32'd0);
        check("reset_b", {19'd0, x_b, y_b, busy_b, done_b, cnt_b, flag_b, fx_b, fy_b}, 32'd0);
        rst = 1'b0;

        run_sweep(2, 2, 0, 0, 1'b0);
        run_sweep(2, 2, 1, 0, 1'b0);
        run_sweep(2, 2, 0, 0, 1'b1);
        run_sweep(7, 7, 0, 0, 1'b0);
        run_sweep(2, 2, 2, 0, 1'b0);
        run_sweep(7, 7, 2, 0, 1'b0);
        run_sweep(0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(255, 0)),
                      1'($urandom_range(1, 0)));
        end

        // Asynchronous reset while pair (1,1) is on the operands.
        mode = 1;
        @(negedge clk);
        x_lim = 3'd2;
        y_lim = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 8; n++) @(negedge clk);
        check("pre_reset_pair", {24'd0, busy_a, x_a, y_a}, {24'd0, 1'b1, 3'd1, 3'd1});
        #2 rst = 1'b1;
        #1;
        check("async_reset_a", {13'd0, x_a, y_a, busy_a, done_a, cnt_a, flag_a, fx_a, fy_a}, 32'd0);
        check("async_reset_b", {19'd0, x_b, y_b, busy_b, done_b, cnt_b, flag_b, fx_b, fy_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(1, 1, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
